clk_freq_monitor: RTL and testbench
===================================

Name: clk_freq_monitor

Overview:
Checks a divided clock from the clock divider (10 kHz or 1 kHz output) from the 50 MHz side. It synchronises the monitored clock and measures each rising-edge-to-rising-edge period in 50 MHz cycles. It declares lock after N consecutive in-tolerance periods and flags sticky faults on bad periods or a stuck clock. It sits beside the divider in the digital clock top and feeds a status LED and debug readout.

Parameters:
EXP_PERIOD, 5000, expected period in clk_in_50M cycles (5000 = 10 kHz; 50000 = 1 kHz)
TOL, 2, allowed absolute deviation from EXP_PERIOD, in cycles
LOCK_CNT, 4, consecutive good periods required to lock
CNT_W, 17, period counter width; must satisfy 2^CNT_W > 2*EXP_PERIOD

Ports:
clk_in_50M  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
clk_mon  input  1  divided clock under test, treated as asynchronous
clr_err  input  1  synchronous clear of fault and err_cnt
locked  output  1  lock achieved, frequency in tolerance
fault  output  1  sticky fault flag
period_valid  output  1  one-cycle pulse: period_last updated
period_last  output  CNT_W  most recent measured period
err_cnt  output  8  bad-period/timeout count, saturates at 255
high_last  output  CNT_W  measured high time (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; counters 0.
- Synchronisation: 2-FF synchroniser, then an edge register. The rise pulse occurs in the 3rd clk_in_50M cycle after the clk_mon rising edge is sampled.
- Counter cnt, in every cycle with a rise pulse:
  - period_last <= cnt+1
  - cnt <= 0
- Counter cnt, otherwise: cnt increments, saturating at all-ones.
- Ideal 10 kHz input gives period_last=5000.
- period_valid is registered and pulses the cycle after each rise pulse, except the first rise seen in IDLE.
- good = |(cnt+1) - EXP_PERIOD| <= TOL, computed as unsigned compare, no overflow.
- timeout = no rise pulse and cnt+1 == 2*EXP_PERIOD.
- State IDLE:
  - rise -> ACQUIRE, good_cnt=0, no measurement.
  - timeout -> FAULT.
- State ACQUIRE:
  - good rise -> good_cnt+1; on reaching LOCK_CNT -> LOCKED.
  - bad rise -> good_cnt=0, err_cnt+1, stay in ACQUIRE.
  - timeout -> FAULT, err_cnt+1.
- State LOCKED:
  - good rise -> stay.
  - bad rise or timeout -> FAULT, err_cnt+1.
- State FAULT:
  - Stays until clr_err; measurement continues and period_valid still pulses.
  - clr_err -> IDLE, err_cnt=0.
- Outputs: locked = (state==LOCKED); fault = (state==FAULT). Both registered, updating the same edge as the state.
- Simultaneous events:
  - clr_err beats rise/timeout: that edge is ignored for state, and cnt still resets.
  - clr_err outside FAULT clears err_cnt only.
- err_cnt saturates at 255.
- rst_n asserted mid-operation: immediate return to reset values; no partial measurement survives.

Optional Feature:
DUTY_CHECK_EN
- Defined:
  - high_last captures clk_mon high time in cycles, measured rise to fall.
  - A rise whose preceding high time deviates from EXP_PERIOD/2 by more than TOL is treated as bad.
- Undefined: high_last tied to 0; duty cycle ignored.

Decomposition:
- Package clk_mon_pkg:
  - state enum (IDLE, ACQUIRE, LOCKED, FAULT)
  - ERR_CNT_W=8
  - SYNC_STAGES=2
- Sub-module sync_edge_det:
  - 2-FF synchroniser plus rise/fall single-cycle pulses
  - reused later for button inputs

Test Plan:
- Ideal 10 kHz clk_mon (toggle every 2500 cycles) -> period_valid pulses with period_last=5000; locked=1 one cycle after the 5th rise pulse; err_cnt=0.
- After lock, one period of 5003 -> fault=1, locked=0, err_cnt=1 on that rise; with TOL=2, 5002 keeps locked=1.
- After lock, hold clk_mon low -> fault=1 when cnt+1 reaches 10000 with no rise; err_cnt=1.
- In FAULT, assert clr_err in the same cycle as a rise pulse -> state IDLE, err_cnt=0, no lock credit; lock again after 5 more good rises.
- Alternating periods 4999/5001 -> remains locked, err_cnt=0. Periods of 4997 during ACQUIRE -> err_cnt increments per rise and never locks.
- Assert rst_n low mid-ACQUIRE -> all outputs 0 asynchronously. After release, the first rise produces no period_valid.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared state type, widths and helpers for the clock frequency monitor
// and its edge-detect front end.
package clk_mon_pkg;

  localparam int ERR_CNT_W   = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } mon_state_e;

  // Error count sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
    logic [ERR_CNT_W-1:0] r;
    if (v == {ERR_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + ERR_CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser for an asynchronous level, followed by an edge register that
// produces single-cycle rise/fall pulses in the local clock domain.
module sync_edge_det
  import clk_mon_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one delayed copy of its output for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// Measures the period of a slow asynchronous clock in system-clock cycles and
// tracks lock/fault status. Define DUTY_CHECK_EN to also measure and check high time.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_PERIOD = 5000,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int CNT_W      = 17
) (
  input  logic                 clk_in_50M,
  input  logic                 rst_n,
  input  logic                 clk_mon,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 fault,
  output logic                 period_valid,
  output logic [CNT_W-1:0]     period_last,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0]     high_last
);

  localparam int               GC_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W:0]   LO_LIM  = (CNT_W+1)'(EXP_PERIOD - TOL);
  localparam logic [CNT_W:0]   HI_LIM  = (CNT_W+1)'(EXP_PERIOD + TOL);
  localparam logic [CNT_W:0]   TO_LIM  = (CNT_W+1)'(2 * EXP_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic                 rise_s, fall_s, good_s, duty_ok_s, bad_s, timeout_s, inc_err_s;
  logic [CNT_W:0]       meas_s;
  logic [CNT_W-1:0]     meas_sat_s;
  logic [CNT_W-1:0]     cnt_q, cnt_d, plast_q, plast_d;
  mon_state_e           state_q, state_d;
  logic [GC_W-1:0]      gc_q, gc_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 valid_q, valid_d, locked_q, fault_q;

  sync_edge_det u_sync (
    .clk_i   (clk_in_50M),
    .rst_ni  (rst_n),
    .async_i (clk_mon),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  // One extra bit keeps cnt+1 exact even when cnt is saturated.
  assign meas_s     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign meas_sat_s = (cnt_q == CNT_MAX) ? CNT_MAX : meas_s[CNT_W-1:0];
  assign good_s     = (meas_s >= LO_LIM) && (meas_s <= HI_LIM);
  assign timeout_s  = ~rise_s && (meas_s == TO_LIM);
  assign bad_s      = ~(good_s & duty_ok_s);

`ifdef DUTY_CHECK_EN
  localparam logic [CNT_W-1:0] HLO = CNT_W'(EXP_PERIOD / 2 - TOL);
  localparam logic [CNT_W-1:0] HHI = CNT_W'(EXP_PERIOD / 2 + TOL);

  logic [CNT_W-1:0] hcnt_q, hcnt_d, high_q, high_d;

  // High-time counter restarts on each rise and is captured on the following fall.
  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    if (rise_s) begin
      hcnt_d = {CNT_W{1'b0}};
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + CNT_W'(1);
    end else begin
      hcnt_d = hcnt_q;
    end
    if (fall_s) begin
      high_d = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CNT_W'(1);
    end else begin
      high_d = high_q;
    end
  end

  always_ff @(posedge clk_in_50M or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= {CNT_W{1'b0}};
      high_q <= {CNT_W{1'b0}};
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign duty_ok_s = (high_q >= HLO) && (high_q <= HHI);
  assign high_last = high_q;
`else
  logic unused_fall_s;
  assign unused_fall_s = fall_s;
  assign duty_ok_s     = 1'b1;
  assign high_last     = {CNT_W{1'b0}};
`endif

  // Period counter, measurement capture and lock/fault state machine.
  always_comb begin
    cnt_d     = cnt_q;
    plast_d   = plast_q;
    valid_d   = 1'b0;
    state_d   = state_q;
    gc_d      = gc_q;
    inc_err_s = 1'b0;
    if (rise_s) begin
      cnt_d   = {CNT_W{1'b0}};
      plast_d = meas_sat_s;
      valid_d = (state_q != IDLE);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = ACQUIRE;
          gc_d    = {GC_W{1'b0}};
        end else if (timeout_s) begin
          state_d = FAULT;
        end else begin
          state_d = IDLE;
        end
      end
      ACQUIRE: begin
        if (rise_s && !bad_s) begin
          if (gc_q == GC_W'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            gc_d    = {GC_W{1'b0}};
          end else begin
            gc_d = gc_q + GC_W'(1);
          end
        end else if (rise_s) begin
          gc_d      = {GC_W{1'b0}};
          inc_err_s = 1'b1;
        end else if (timeout_s) begin
          state_d   = FAULT;
          inc_err_s = 1'b1;
        end else begin
          state_d = ACQUIRE;
        end
      end
      LOCKED: begin
        if ((rise_s && bad_s) || timeout_s) begin
          state_d   = FAULT;
          inc_err_s = 1'b1;
        end else begin
          state_d = LOCKED;
        end
      end
      FAULT: begin
        // A clear in FAULT takes priority over any same-cycle rise or timeout.
        if (clr_err) begin
          state_d = IDLE;
          gc_d    = {GC_W{1'b0}};
        end else begin
          state_d = FAULT;
        end
      end
      default: begin
        state_d = IDLE;
        gc_d    = {GC_W{1'b0}};
      end
    endcase
    if (clr_err) begin
      err_d = {ERR_CNT_W{1'b0}};
    end else if (inc_err_s) begin
      err_d = err_sat_inc(err_q);
    end else begin
      err_d = err_q;
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk_in_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      plast_q  <= {CNT_W{1'b0}};
      gc_q     <= {GC_W{1'b0}};
      err_q    <= {ERR_CNT_W{1'b0}};
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      plast_q  <= plast_d;
      gc_q     <= gc_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      locked_q <= (state_d == LOCKED);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign locked       = locked_q;
  assign fault        = fault_q;
  assign period_valid = valid_q;
  assign period_last  = plast_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Self-checking bench for clk_freq_monitor: drives clk_mon waveforms period by
// period and compares against a rise-by-rise behavioural model.
module tb_clk_freq_monitor;

  localparam int EXP  = 200;
  localparam int TOL  = 2;
  localparam int LCK  = 4;
  localparam int CW   = 9;
  localparam int CMAX = (1 << CW) - 1;
  // Rise drive to rise registration is 3 cycles; timeout fires 2*EXP cycles after that.
  localparam int TO_S = 2 * EXP + 3;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FLT = 3;

  logic          clk = 1'b0;
  logic          rst_n, clk_mon, clr_err;
  logic          locked, fault, period_valid;
  logic [CW-1:0] period_last, high_last;
  logic [7:0]    err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int ms, m_good, m_err, since, prev_h;
  bit armed, to_done;

  always #10 clk = ~clk;

  clk_freq_monitor #(
    .EXP_PERIOD (EXP),
    .TOL        (TOL),
    .LOCK_CNT   (LCK),
    .CNT_W      (CW)
  ) dut (
    .clk_in_50M   (clk),
    .rst_n        (rst_n),
    .clk_mon      (clk_mon),
    .clr_err      (clr_err),
    .locked       (locked),
    .fault        (fault),
    .period_valid (period_valid),
    .period_last  (period_last),
    .err_cnt      (err_cnt),
    .high_last    (high_last)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit in_tol(input int v, input int c);
    return (v >= c - TOL) && (v <= c + TOL);
  endfunction

  task automatic model_reset();
    ms = M_IDLE; m_good = 0; m_err = 0; since = 0; prev_h = 0;
    armed = 1'b0; to_done = 1'b0;
  endtask

  task automatic err_up();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_to();
    if (ms == M_ACQ || ms == M_LOCK) begin
      ms = M_FLT;
      err_up();
    end else if (ms == M_IDLE) begin
      ms = M_FLT;
    end
    to_done = 1'b1;
  endtask

  task automatic model_rise(input int meas, input bit clr, input bit wa, output bit exp_valid);
    bit good;
    if (wa && !to_done && meas > 2 * EXP) model_to();
    exp_valid = (ms != M_IDLE);
    good = in_tol(meas, EXP);
`ifdef DUTY_CHECK_EN
    good = good && in_tol(prev_h, EXP / 2);
`endif
    if (clr && ms == M_FLT) begin
      ms = M_IDLE;
    end else begin
      case (ms)
        M_IDLE: begin ms = M_ACQ; m_good = 0; end
        M_ACQ: begin
          if (good) begin
            m_good++;
            if (m_good == LCK) ms = M_LOCK;
          end else begin
            m_good = 0;
            err_up();
          end
        end
        M_LOCK: if (!good) begin ms = M_FLT; err_up(); end
        default: ;
      endcase
    end
    if (clr) m_err = 0;
    to_done = 1'b0;
  endtask

  task automatic check_state();
    check_val("locked", 32'(locked), 32'(ms == M_LOCK));
    check_val("fault", 32'(fault), 32'(ms == M_FLT));
    check_val("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  // One clk_mon period of p cycles, high for the first h (h=0: hold low, no rise).
  task automatic drive(input int p, input int h, input bit clr);
    int meas;
    bit wa, ev;
    meas = 0; wa = 1'b0; ev = 1'b0;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      since++;
      if (armed && !to_done && since == TO_S - 1)
        check_val("fault_before_timeout", 32'(fault), 32'(ms == M_FLT));
      if (armed && !to_done && since == TO_S) begin
        model_to();
        check_state();
      end
      if (h > 0 && i == 0) begin
        meas = since; since = 0; wa = armed; armed = 1'b1;
      end
      if (h > 0 && clr && i == 2) clr_err = 1'b1;
      if (h > 0 && i == 3) begin
        model_rise(meas, clr, wa, ev);
        check_val("period_valid", 32'(period_valid), 32'(ev));
        if (ev) check_val("period_last", 32'(period_last), 32'((meas > CMAX) ? CMAX : meas));
`ifdef DUTY_CHECK_EN
        check_val("high_last", 32'(high_last), 32'(prev_h));
`else
        check_val("high_last", 32'(high_last), 32'(0));
`endif
        check_state();
        clr_err = 1'b0;
      end
      clk_mon = (i < h);
    end
    if (h > 0) prev_h = h;
  endtask

  task automatic good_p(input int p);
    drive(p, p / 2, 1'b0);
  endtask

  task automatic quiet_clear();
    @(negedge clk); since++; clr_err = 1'b1;
    @(negedge clk); since++; clr_err = 1'b0;
    m_err = 0;
    check_state();
  endtask

  task automatic check_zero();
    check_val("rst_locked", 32'(locked), 32'(0));
    check_val("rst_fault", 32'(fault), 32'(0));
    check_val("rst_valid", 32'(period_valid), 32'(0));
    check_val("rst_period", 32'(period_last), 32'(0));
    check_val("rst_err", 32'(err_cnt), 32'(0));
    check_val("rst_high", 32'(high_last), 32'(0));
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst_n = 1'b0; clk_mon = 1'b0;
    #1;
    check_zero();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r, p;
    bit c;
    rst_n = 1'b0; clk_mon = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero();
    rst_n = 1'b1;

    // Acquire and lock on nominal periods, then stay locked across tolerance.
    for (int k = 0; k < 5; k++) good_p(EXP);
    for (int k = 0; k < 4; k++) good_p((k % 2 == 0) ? EXP - 1 : EXP + 1);
    good_p(EXP + TOL);
    good_p(EXP - TOL);
    good_p(EXP + TOL + 1);

    // Clear coinciding with a rise, then relock.
    drive(EXP, EXP / 2, 1'b1);
    for (int k = 0; k < 5; k++) good_p(EXP);

    // Stuck-low timeout from lock, then clear.
    drive(TO_S + 20, 0, 1'b0);
    drive(EXP, EXP / 2, 1'b1);

    // Short periods during acquisition never lock.
    good_p(EXP);
    for (int k = 0; k < 3; k++) good_p(EXP - TOL - 1);
    quiet_clear();
    good_p(EXP - TOL - 1);
    mid_reset();
    good_p(EXP);

    // Error counter saturation, then timeout and counter saturation in FAULT.
    for (int k = 0; k < 260; k++) drive(12, 6, 1'b0);
    drive(600, 0, 1'b0);
    drive(EXP, EXP / 2, 1'b1);

    // Randomised mix of good, bad and stuck periods with occasional clears.
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 19));
      c = (ms == M_FLT) && ($urandom_range(0, 1) == 1);
      if (r < 14) begin
        p = EXP - TOL + int'($urandom_range(0, 2 * TOL));
        drive(p, p / 2, c);
      end else if (r < 19) begin
        p = TOL + 1 + int'($urandom_range(0, 4));
        p = ($urandom_range(0, 1) == 1) ? EXP + p : EXP - p;
        drive(p, p / 2, c);
      end else begin
        drive(TO_S + int'($urandom_range(0, 30)), 0, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
